// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
package cpu_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBranch
  } state_e;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOrr = 2'b11;

  localparam logic [1:0] OpDp     = 2'b00;
  localparam logic [1:0] OpMem    = 2'b01;
  localparam logic [1:0] OpBranch = 2'b10;
  localparam logic [1:0] OpNop    = 2'b11;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdCmp = 4'b1010;
  localparam logic [3:0] CmdOrr = 4'b1100;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// Stored NZCV flags and condition-code evaluation against them.
module cond_unit
  import cpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_write_i,
  output logic       cond_ex_o
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  // Evaluated from the registered flags, so a same-cycle update is not seen.
  always_comb begin
    cond_ex_o = 1'b0;
    unique case (cond_i)
      CondEq:  cond_ex_o = z;
      CondNe:  cond_ex_o = ~z;
      CondCs:  cond_ex_o = c;
      CondCc:  cond_ex_o = ~c;
      CondMi:  cond_ex_o = n;
      CondPl:  cond_ex_o = ~n;
      CondVs:  cond_ex_o = v;
      CondVc:  cond_ex_o = ~v;
      CondHi:  cond_ex_o = c & ~z;
      CondLs:  cond_ex_o = ~(c & ~z);
      CondGe:  cond_ex_o = (n == v);
      CondLt:  cond_ex_o = (n != v);
      CondGt:  cond_ex_o = ~z & (n == v);
      CondLe:  cond_ex_o = ~(~z & (n == v));
      CondAl:  cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_write_i[1]) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_write_i[0]) flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flags_q <= '0;
    else         flags_q <= flags_d;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM; datapath controls decoded from state and Instr.
module multicycle_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
);

  state_e     state_q, state_d;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       s_bit;
  logic       cond_ex;
  logic [1:0] dp_alu;
  logic       no_write;
  logic       cv_cmd;
  logic       is_exec;
  logic [1:0] flag_write;
  logic       pc_w, ir_w, reg_w, mem_w;
  logic       unused_instr;

  assign op           = Instr[27:26];
  assign cmd          = Instr[24:21];
  assign s_bit        = Instr[20];
  assign unused_instr = ^Instr[19:0];

  always_comb begin
    dp_alu   = AluAdd;
    no_write = 1'b0;
    cv_cmd   = 1'b0;
    unique case (cmd)
      CmdAdd:  begin dp_alu = AluAdd; cv_cmd = 1'b1; end
      CmdSub:  begin dp_alu = AluSub; cv_cmd = 1'b1; end
      CmdAnd:  dp_alu = AluAnd;
      CmdOrr:  dp_alu = AluOrr;
      CmdCmp:  begin dp_alu = AluSub; cv_cmd = 1'b1; no_write = 1'b1; end
      default: begin dp_alu = AluAdd; no_write = 1'b1; end
    endcase
  end

  assign is_exec    = (state_q == StExecuteR) || (state_q == StExecuteI);
  assign flag_write = {is_exec & s_bit & cond_ex, is_exec & s_bit & cond_ex & cv_cmd};

  cond_unit u_cond (
    .clk_i        (clk),
    .rst_ni       (reset),
    .cond_i       (Instr[31:28]),
    .alu_flags_i  (ALUFlags),
    .flag_write_i (flag_write),
    .cond_ex_o    (cond_ex)
  );

  always_comb begin
    state_d    = state_q;
    pc_w       = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = AluAdd;
    unique case (state_q)
      StFetch: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_w      = MemReady;
        ir_w      = MemReady;
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (op)
          OpMem:    state_d = StMemAdr;
          OpDp:     state_d = Instr[25] ? StExecuteI : StExecuteR;
          OpBranch: state_d = StBranch;
          OpNop:    state_d = StFetch;
          default:  state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSrcB = 2'b01;
        state_d = s_bit ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_w     = cond_ex;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc = 1'b1;
        mem_w  = cond_ex;
        if (MemReady) state_d = StFetch;
      end
      StExecuteR: begin
        ALUControl = dp_alu;
        state_d    = StAluWb;
      end
      StExecuteI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dp_alu;
        state_d    = StAluWb;
      end
      StAluWb: begin
        reg_w   = cond_ex & ~no_write;
        state_d = StFetch;
      end
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_w      = cond_ex;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Write strobes are masked by reset so an aborted access never commits.
  assign PCWrite  = pc_w & reset;
  assign IRWrite  = ir_w & reset;
  assign RegWrite = reg_w & reset;
  assign MemWrite = mem_w & reset;

  assign ImmSrc = op;
  assign RegSrc = {(op == OpMem) & ~s_bit, op == OpBranch};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: expected per-cycle control vectors are queued per instruction.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] act;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                ImmSrc, RegSrc, ALUControl};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] ev(input logic [31:0] ins, input logic pcw, irw, rw, mw, adr,
                                     srca, input logic [1:0] srcb, rs, alu);
    logic [1:0] rsrc;
    rsrc = {(ins[27:26] == 2'b01) && !ins[20], ins[27:26] == 2'b10};
    return {pcw, irw, rw, mw, adr, srca, srcb, rs, ins[27:26], rsrc, alu};
  endfunction

  task automatic push(input string tag, input logic [15:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic cyc(input logic mr, input logic [3:0] fl);
    MemReady = mr;
    ALUFlags = fl;
    @(negedge clk);
    if (exp_q.size() == 0) check_eq("sb_underflow", 16'(exp_q.size()), 16'd1);
    else check_eq(tag_q.pop_front(), act, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] want);
    check_eq(tag, {12'd0, dut.u_cond.flags_q}, {12'd0, want});
  endtask

  task automatic push_fd(input string nm, input logic [31:0] ins);
    push({nm, "_fetch"},  ev(ins, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
    push({nm, "_decode"}, ev(ins, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
  endtask

  // Data-processing instruction: FETCH, DECODE, EXECUTE(R/I), ALUWB.
  task automatic run_dp(input string nm, input logic [31:0] ins, input logic [1:0] alu,
                        input logic rw, input logic [3:0] fl);
    Instr = ins;
    push_fd(nm, ins);
    push({nm, "_exec"}, ev(ins, 0, 0, 0, 0, 0, 0, ins[25] ? 2'b01 : 2'b00, 2'b00, alu));
    push({nm, "_aluwb"}, ev(ins, 0, 0, rw, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    cyc(1, 4'h0);
    cyc(1, 4'h0);
    cyc(1, fl);
    cyc(1, 4'h0);
  endtask

  task automatic run_branch(input string nm, input logic [31:0] ins, input logic pcw);
    Instr = ins;
    push_fd(nm, ins);
    push({nm, "_branch"}, ev(ins, pcw, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00));
    repeat (3) cyc(1, 4'h0);
  endtask

  localparam logic [31:0] Add   = 32'hE082_1003;
  localparam logic [31:0] Ldr   = 32'hE592_1004;
  localparam logic [31:0] Str   = 32'hE582_1004;
  localparam logic [31:0] Subs  = 32'hE051_1001;
  localparam logic [31:0] Beq   = 32'h0A00_0002;
  localparam logic [31:0] Bne   = 32'h1A00_0002;
  localparam logic [31:0] Adds  = 32'hE092_1003;
  localparam logic [31:0] Cmp   = 32'hE151_0001;
  localparam logic [31:0] Ands  = 32'hE011_1002;
  localparam logic [31:0] Addeq = 32'h0092_1003;
  localparam logic [31:0] Orri  = 32'hE381_1001;
  localparam logic [31:0] AddNv = 32'hF082_1003;
  localparam logic [31:0] Nop   = 32'hEC00_0000;

  initial begin
    reset    = 1'b0;
    Instr    = Add;
    ALUFlags = 4'hF;
    MemReady = 1'b1;
    @(negedge clk);
    check_eq("reset_out", act, ev(Add, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
    chk_flags("reset_flags", 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fetch stalls while memory is not ready.
    push("fetch_wait", ev(Add, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
    cyc(0, 4'h0);
    run_dp("add", Add, 2'b00, 1, 4'hF);
    chk_flags("add_noS_flags", 4'h0);

    // LDR with three wait cycles in MEMREAD.
    Instr = Ldr;
    push_fd("ldr", Ldr);
    push("ldr_memadr", ev(Ldr, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
    for (int i = 0; i < 4; i++) push("ldr_memread", ev(Ldr, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
    push("ldr_memwb", ev(Ldr, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    repeat (3) cyc(1, 4'h0);
    repeat (3) cyc(0, 4'h0);
    cyc(1, 4'h0);
    cyc(1, 4'h0);

    run_dp("subs", Subs, 2'b01, 1, 4'b0110);
    chk_flags("subs_flags", 4'b0110);
    run_branch("beq", Beq, 1'b1);
    run_branch("bne", Bne, 1'b0);
    chk_flags("branch_flags", 4'b0110);

    run_dp("adds", Adds, 2'b00, 1, 4'b1000);
    chk_flags("adds_flags", 4'b1000);
    run_dp("cmp", Cmp, 2'b01, 0, 4'b0110);
    chk_flags("cmp_flags", 4'b0110);
    run_dp("ands", Ands, 2'b10, 1, 4'b1011);
    chk_flags("ands_flags", 4'b1010);
    run_dp("addeq_false", Addeq, 2'b00, 0, 4'b0100);
    chk_flags("addeq_flags", 4'b1010);
    run_dp("orr_imm", Orri, 2'b11, 1, 4'hF);
    chk_flags("orr_flags", 4'b1010);
    run_dp("add_nv", AddNv, 2'b00, 0, 4'h0);

    Instr = Nop;
    push_fd("nop", Nop);
    repeat (2) cyc(1, 4'h0);

    // STR completing after one wait cycle.
    Instr = Str;
    push_fd("str", Str);
    push("str_memadr", ev(Str, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
    push("str_wait", ev(Str, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00));
    push("str_done", ev(Str, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00));
    repeat (3) cyc(1, 4'h0);
    cyc(0, 4'h0);
    cyc(1, 4'h0);

    // STR aborted by reset in the MEMWRITE wait.
    push_fd("str2", Str);
    push("str2_memadr", ev(Str, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
    push("str2_wait", ev(Str, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00));
    repeat (3) cyc(1, 4'h0);
    cyc(0, 4'h0);
    #2;
    check_eq("str2_hold", act, ev(Str, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00));
    reset = 1'b0;
    #1;
    check_eq("str2_abort", act, ev(Str, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
    chk_flags("str2_flags", 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_dp("add_after_rst", Add, 2'b00, 1, 4'h0);
    check_eq("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
